// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: register file, load-use bubble control and the ID/EX pipeline register.
// Optional build macro WB_BYPASS_EN: write-through of the WB port into captured operands.
module id_operand_stage #(
  parameter int unsigned NBITS      = 32,
  parameter int unsigned NREG_BITS  = 5,
  parameter int unsigned LOAD_DELAY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [NBITS-1:0]     i_pc,
  input  logic [NREG_BITS-1:0] i_rs_sel,
  input  logic [NREG_BITS-1:0] i_rt_sel,
  input  logic [NREG_BITS-1:0] i_rd_sel,
  input  logic                 i_flg_reg_wr_en,
  input  logic                 i_flg_mem_rd,
  input  logic                 i_flush,
  input  logic                 i_ex_stall,
  input  logic [NREG_BITS-1:0] i_wb_rd_sel,
  input  logic                 i_wb_wr_en,
  input  logic [NBITS-1:0]     i_wb_data,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic [NBITS-1:0]     o_pc,
  output logic [NBITS-1:0]     o_rs_data,
  output logic [NBITS-1:0]     o_rt_data,
  output logic [NREG_BITS-1:0] o_rs,
  output logic [NREG_BITS-1:0] o_rt,
  output logic [NREG_BITS-1:0] o_rd,
  output logic                 o_flg_reg_wr_en,
  output logic                 o_flg_mem_rd
);

  localparam int unsigned NREG  = 1 << NREG_BITS;
  localparam int unsigned CNT_W = 3;
  // First HOLD count: the RUN cycle that detects the hazard already emits one bubble.
  localparam logic [CNT_W-1:0] HOLD_INIT = (LOAD_DELAY > 1) ? CNT_W'(LOAD_DELAY - 2) : '0;

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [NBITS-1:0]     pc_q, pc_d;
  logic [NBITS-1:0]     rs_data_q, rs_data_d;
  logic [NBITS-1:0]     rt_data_q, rt_data_d;
  logic [NREG_BITS-1:0] rs_q, rs_d;
  logic [NREG_BITS-1:0] rt_q, rt_d;
  logic [NREG_BITS-1:0] rd_q, rd_d;
  logic                 wr_en_q, wr_en_d;
  logic                 mem_rd_q, mem_rd_d;

  logic [NBITS-1:0]     rf_q [NREG];
  logic [NBITS-1:0]     rs_rd_c, rt_rd_c;
  logic                 wb_we_c, haz_c, bubble_c;

  assign wb_we_c = i_wb_wr_en && (i_wb_rd_sel != '0);

  // Register file read ports; r0 is hard-wired to zero.
  always_comb begin
    rs_rd_c = (i_rs_sel == '0) ? '0 : rf_q[i_rs_sel];
    rt_rd_c = (i_rt_sel == '0) ? '0 : rf_q[i_rt_sel];
`ifdef WB_BYPASS_EN
    if (wb_we_c && (i_wb_rd_sel == i_rs_sel)) rs_rd_c = i_wb_data;
    if (wb_we_c && (i_wb_rd_sel == i_rt_sel)) rt_rd_c = i_wb_data;
`endif
  end

  assign haz_c = i_valid && valid_q && mem_rd_q && (rd_q != '0) &&
                 ((rd_q == i_rs_sel) || (rd_q == i_rt_sel));
  assign bubble_c = ((state_q == ST_RUN) && haz_c) || (state_q == ST_HOLD);
  assign o_stall  = !i_rst && !i_flush && (i_ex_stall || bubble_c);

  // Next-state: flush > EX stall > bubble > normal capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    wr_en_d   = wr_en_q;
    mem_rd_d  = mem_rd_q;
    if (i_flush) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      valid_d  = 1'b0;
      wr_en_d  = 1'b0;
      mem_rd_d = 1'b0;
    end else if (i_ex_stall) begin
      state_d = state_q;
    end else if (bubble_c) begin
      valid_d  = 1'b0;
      wr_en_d  = 1'b0;
      mem_rd_d = 1'b0;
      if (state_q == ST_RUN) begin
        if (LOAD_DELAY > 1) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end else if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      valid_d   = i_valid;
      pc_d      = i_pc;
      rs_data_d = rs_rd_c;
      rt_data_d = rt_rd_c;
      rs_d      = i_rs_sel;
      rt_d      = i_rt_sel;
      rd_d      = i_rd_sel;
      wr_en_d   = i_valid && i_flg_reg_wr_en;
      mem_rd_d  = i_valid && i_flg_mem_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      mem_rd_q  <= mem_rd_d;
      // WB writes land even while ID/EX is stalled or flushed.
      if (wb_we_c) rf_q[i_wb_rd_sel] <= i_wb_data;
    end
  end

  assign o_valid         = valid_q;
  assign o_pc            = pc_q;
  assign o_rs_data       = rs_data_q;
  assign o_rt_data       = rt_data_q;
  assign o_rs            = rs_q;
  assign o_rt            = rt_q;
  assign o_rd            = rd_q;
  assign o_flg_reg_wr_en = wr_en_q;
  assign o_flg_mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed load-use scenarios followed by random traffic against a bubble-debt model.
module tb_id_operand_stage;

  localparam int unsigned NBITS      = 32;
  localparam int unsigned NREG_BITS  = 5;
  localparam int unsigned LOAD_DELAY = 3;

  logic                 clk;
  logic                 i_rst, i_valid, i_flg_reg_wr_en, i_flg_mem_rd, i_flush, i_ex_stall, i_wb_wr_en;
  logic [NBITS-1:0]     i_pc, i_wb_data;
  logic [NREG_BITS-1:0] i_rs_sel, i_rt_sel, i_rd_sel, i_wb_rd_sel;
  logic                 o_stall, o_valid, o_flg_reg_wr_en, o_flg_mem_rd;
  logic [NBITS-1:0]     o_pc, o_rs_data, o_rt_data;
  logic [NREG_BITS-1:0] o_rs, o_rt, o_rd;

  id_operand_stage #(.NBITS(NBITS), .NREG_BITS(NREG_BITS), .LOAD_DELAY(LOAD_DELAY)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_pc(i_pc),
    .i_rs_sel(i_rs_sel), .i_rt_sel(i_rt_sel), .i_rd_sel(i_rd_sel),
    .i_flg_reg_wr_en(i_flg_reg_wr_en), .i_flg_mem_rd(i_flg_mem_rd),
    .i_flush(i_flush), .i_ex_stall(i_ex_stall),
    .i_wb_rd_sel(i_wb_rd_sel), .i_wb_wr_en(i_wb_wr_en), .i_wb_data(i_wb_data),
    .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_flg_reg_wr_en(o_flg_reg_wr_en), .o_flg_mem_rd(o_flg_mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural registers, expected ID/EX contents and outstanding bubble debt.
  logic [31:0] regs [32];
  logic        m_valid, m_wr, m_mrd, m_stall;
  logic [31:0] m_pc, m_a, m_b;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          owed;

  function automatic logic [31:0] model_read(input logic [4:0] sel);
    if (sel == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (i_wb_wr_en && i_wb_rd_sel == sel) return i_wb_data;
`endif
    return regs[sel];
  endfunction

  task automatic step();
    logic haz;
    logic [31:0] a, b;
    #1;
    haz = i_valid && m_valid && m_mrd && (m_rd != 5'd0) && (m_rd == i_rs_sel || m_rd == i_rt_sel);
    m_stall = !i_rst && !i_flush && (i_ex_stall || owed > 0 || haz);
    check("stall", 32'(o_stall), 32'(m_stall));
    a = model_read(i_rs_sel);
    b = model_read(i_rt_sel);
    if (i_rst) begin
      foreach (regs[i]) regs[i] = '0;
      m_valid = 0; m_wr = 0; m_mrd = 0; m_pc = 0; m_a = 0; m_b = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; owed = 0;
    end else begin
      if (i_flush) begin
        m_valid = 0; m_wr = 0; m_mrd = 0; owed = 0;
      end else if (i_ex_stall) begin
        owed = owed;
      end else if (owed > 0 || haz) begin
        owed = (owed > 0) ? owed - 1 : int'(LOAD_DELAY) - 1;
        m_valid = 0; m_wr = 0; m_mrd = 0;
      end else begin
        m_valid = i_valid; m_pc = i_pc; m_a = a; m_b = b;
        m_rs = i_rs_sel; m_rt = i_rt_sel; m_rd = i_rd_sel;
        m_wr = i_valid && i_flg_reg_wr_en; m_mrd = i_valid && i_flg_mem_rd;
      end
      if (i_wb_wr_en && i_wb_rd_sel != 5'd0) regs[i_wb_rd_sel] = i_wb_data;
    end
    @(posedge clk);
    #1;
    check("valid", 32'(o_valid), 32'(m_valid));
    check("wr_en", 32'(o_flg_reg_wr_en), 32'(m_wr));
    check("mem_rd", 32'(o_flg_mem_rd), 32'(m_mrd));
    if (m_valid) begin
      check("pc", o_pc, m_pc);
      check("rs_data", o_rs_data, m_a);
      check("rt_data", o_rt_data, m_b);
      check("rs", 32'(o_rs), 32'(m_rs));
      check("rt", 32'(o_rt), 32'(m_rt));
      check("rd", 32'(o_rd), 32'(m_rd));
    end
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic wr, input logic mr);
    i_valid = v; i_pc = $urandom; i_rs_sel = rs; i_rt_sel = rt; i_rd_sel = rd;
    i_flg_reg_wr_en = wr; i_flg_mem_rd = mr;
  endtask

  task automatic clr_ctl();
    i_rst = 0; i_flush = 0; i_ex_stall = 0; i_wb_wr_en = 0; i_wb_rd_sel = 0; i_wb_data = 0;
  endtask

  initial begin
    logic [31:0] exp7;
    clr_ctl();
    set_instr(0, 0, 0, 0, 0, 0);
    foreach (regs[i]) regs[i] = '0;
    m_valid = 0; m_wr = 0; m_mrd = 0; m_pc = 0; m_a = 0; m_b = 0;
    m_rs = 0; m_rt = 0; m_rd = 0; owed = 0;

    // Reset state
    i_rst = 1; step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_pc", o_pc, 32'd0);
    check("rst_rs_data", o_rs_data, 32'd0);

    // Write r5 then read it back
    i_rst = 0; i_wb_wr_en = 1; i_wb_rd_sel = 5'd5; i_wb_data = 32'hAA; step();
    i_wb_wr_en = 0; set_instr(1, 5, 0, 9, 1, 0); step();
    check("r5_read", o_rs_data, 32'hAA);
    check("r0_read", o_rt_data, 32'd0);
    check("r5_valid", 32'(o_valid), 32'd1);

    // Same-cycle write and read of r7
`ifdef WB_BYPASS_EN
    exp7 = 32'h1234;
`else
    exp7 = 32'h0;
`endif
    i_wb_wr_en = 1; i_wb_rd_sel = 5'd7; i_wb_data = 32'h1234; set_instr(1, 7, 0, 9, 1, 0); step();
    check("r7_same_cycle", o_rs_data, exp7);
    i_wb_wr_en = 0;

    // Load-use: LOAD_DELAY bubbles then capture
    set_instr(1, 1, 2, 3, 1, 1); step();
    set_instr(1, 4, 3, 5, 1, 0);
    for (int k = 0; k < int'(LOAD_DELAY); k++) begin
      step();
      check("haz_bubble", 32'(o_valid), 32'd0);
    end
    step();
    check("haz_capture", 32'(o_valid), 32'd1);
    check("haz_capture_rt", 32'(o_rt), 32'd3);

    // Load to r0 never stalls
    set_instr(1, 1, 2, 0, 1, 1); step();
    set_instr(1, 0, 0, 6, 1, 0); step();
    check("r0_load_nostall", 32'(o_valid), 32'd1);

    // EX stall in the middle of HOLD
    set_instr(1, 1, 2, 3, 1, 1); step();
    set_instr(1, 3, 4, 6, 1, 0); step();
    i_ex_stall = 1; step(); step();
    check("exst_frozen", 32'(o_valid), 32'd0);
    i_ex_stall = 0;
    for (int k = 1; k < int'(LOAD_DELAY); k++) step();
    check("exst_last_bubble", 32'(o_valid), 32'd0);
    step();
    check("exst_capture", 32'(o_valid), 32'd1);

    // Flush on the hazard cycle
    set_instr(1, 1, 2, 3, 1, 1); step();
    set_instr(1, 3, 4, 6, 1, 0); i_flush = 1; step();
    check("flush_valid", 32'(o_valid), 32'd0);
    i_flush = 0; step();
    check("flush_then_capture", 32'(o_valid), 32'd1);

    // Reset while in HOLD
    set_instr(1, 1, 2, 3, 1, 1); step();
    set_instr(1, 3, 4, 6, 1, 0); step();
    i_rst = 1; step();
    check("rst_hold_valid", 32'(o_valid), 32'd0);
    check("rst_hold_pc", o_pc, 32'd0);
    i_rst = 0; step();
    check("rst_hold_run", 32'(o_valid), 32'd1);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      i_rst       = ($urandom_range(0, 99) == 0);
      i_flush     = ($urandom_range(0, 19) == 0);
      i_ex_stall  = ($urandom_range(0, 7) == 0);
      i_wb_wr_en  = 1'($urandom_range(0, 1));
      i_wb_rd_sel = 5'($urandom_range(0, 7));
      i_wb_data   = $urandom;
      set_instr(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
Parametrised decode-stage operand unit for the pipelined MIPS core. It contains the general-purpose register file with a write-back port and a load-use hazard detector with a programmable bubble count. It also holds the ID/EX pipeline register with stall, flush and valid handling. It sits between the IF/ID register and EX, and replaces the separate register-file/hazard-input arrangement of the current decode top.

Parameters:
NBITS, 32, data and PC width
NREG_BITS, 5, register index width; register count = 2**NREG_BITS
LOAD_DELAY, 1, bubbles inserted per load-use hazard; legal range 1..7

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active high
i_valid  in  1  IF/ID holds a real instruction
i_pc  in  NBITS  PC of the instruction in ID
i_rs_sel  in  NREG_BITS  rs index
i_rt_sel  in  NREG_BITS  rt index
i_rd_sel  in  NREG_BITS  destination index of the instruction in ID
i_flg_reg_wr_en  in  1  instruction in ID writes a register
i_flg_mem_rd  in  1  instruction in ID is a load
i_flush  in  1  squash ID/EX contents (taken jump or branch)
i_ex_stall  in  1  EX cannot accept a new instruction
i_wb_rd_sel  in  NREG_BITS  WB destination index
i_wb_wr_en  in  1  WB write enable
i_wb_data  in  NBITS  WB write data
o_stall  out  1  freeze PC and IF/ID this cycle
o_valid  out  1  ID/EX holds a real instruction
o_pc  out  NBITS  registered PC
o_rs_data  out  NBITS  registered rs operand
o_rt_data  out  NBITS  registered rt operand
o_rs, o_rt, o_rd  out  NREG_BITS each  registered indices
o_flg_reg_wr_en  out  1  registered; forced 0 when o_valid=0
o_flg_mem_rd  out  1  registered; forced 0 when o_valid=0

Behaviour:
- One clock, i_clk. Reset i_rst is synchronous and active high. On reset every register file entry and every registered output is cleared to 0, the FSM goes to RUN and the counter goes to 0. A WB write in the reset cycle is discarded. o_stall=0 while i_rst=1.
- Register file write:
  - At the rising edge, when i_wb_wr_en=1 and i_wb_rd_sel!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Reads are combinational from i_rs_sel/i_rt_sel and are captured into ID/EX at the edge. Latency from ID to outputs is 1 cycle.
- Hazard term: haz = i_valid & o_valid & o_flg_mem_rd & (o_rd!=0) & (o_rd==i_rs_sel | o_rd==i_rt_sel).
- FSM states: RUN and HOLD, with a 3-bit counter cnt.
- Priority at each edge is: rst > i_flush > i_ex_stall > hazard > normal.
  - i_flush: set o_valid=0, state=RUN, cnt=0.
  - i_ex_stall: all ID/EX registers and cnt hold; the register file write still occurs. o_stall=1.
  - RUN with haz: load a bubble (o_valid=0; other fields don't-care but flags 0) and assert o_stall=1. If LOAD_DELAY>1, go to HOLD with cnt=LOAD_DELAY-2.
  - HOLD: load a bubble and assert o_stall=1. If cnt==0, go to RUN; otherwise decrement cnt.
  - Normal: capture all inputs and set o_valid=i_valid. o_stall=0.
- o_stall is combinational: o_stall = ~i_rst & ~i_flush & (i_ex_stall | (RUN & haz) | HOLD).
- Total bubbles per load-use hazard equal LOAD_DELAY exactly, excluding cycles spent in i_ex_stall.
- Held ID/EX operands are frozen. A WB write to a held register is not reflected; the downstream forwarding unit owns that case.

Optional Feature:
WB_BYPASS_EN.
- Defined: when i_wb_wr_en=1, i_wb_rd_sel!=0 and i_wb_rd_sel equals the read index, the captured operand is i_wb_data (write-through in the same cycle).
- Undefined: the captured operand is the pre-write register content. Software or the forwarding path must cover the one-cycle gap.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then write r5=0x0000_00AA. Next cycle read rs=5, rt=0 -> o_rs_data=0xAA, o_rt_data=0, o_valid=1.
- Same-cycle WB write r7=0x1234 and read rs=7:
  - WB_BYPASS_EN defined -> o_rs_data=0x1234.
  - WB_BYPASS_EN undefined -> o_rs_data=old r7 (0 after reset).
- Load with rd=3 in ID/EX, next instruction reads rt=3, LOAD_DELAY=1 -> one cycle o_stall=1, o_valid=0. Following cycle the instruction is captured, o_valid=1.
- Same hazard with LOAD_DELAY=3 -> exactly 3 consecutive cycles of o_stall=1/o_valid=0, then capture. A load to rd=0 followed by a read of rs=0 -> no stall.
- i_ex_stall=1 for 2 cycles mid-HOLD -> outputs and cnt frozen, o_stall=1. Total bubbles still equal LOAD_DELAY.
- i_flush in the cycle a hazard is detected -> o_valid=0, o_stall=0, state RUN. Reset asserted in HOLD -> RUN, cnt=0, outputs 0 next cycle.
